// File: rtl/tmds_rx_channel.sv
// rtl/tmds_rx_channel.sv - TMDS receive channel: symbol decode plus word-alignment FSM.
// Outputs register one cycle after sym; bitslip pulses only from the SLIP state.
module tmds_rx_channel #(
   parameter int MIN_CTRL  = 16,
   parameter int TIMEOUT   = 4096,
   parameter int SLIP_WAIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] sym,
   output logic [7:0] data,
   output logic       de,
   output logic       c0,
   output logic       c1,
   output logic       aligned,
   output logic       bitslip
);

   localparam int RW = $clog2(MIN_CTRL) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int WW = $clog2(SLIP_WAIT) + 1;

   typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   run_q, run_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [7:0]      data_q;
   logic            de_q, c0_q, c1_q, aligned_q, bitslip_q;

   logic            is_ctrl;
   logic [1:0]      ctrl_val;
   logic [7:0]      q_word, dec_byte;
   logic            run_complete, tmo_expired;

   always_comb begin
      is_ctrl  = 1'b1;
      ctrl_val = 2'b00;
      case (sym)
         10'b1101010100: ctrl_val = 2'b00;
         10'b0010101011: ctrl_val = 2'b01;
         10'b0101010100: ctrl_val = 2'b10;
         10'b1010101011: ctrl_val = 2'b11;
         default:        is_ctrl  = 1'b0;
      endcase
   end

   // sym[9] undoes the DC-balance inversion, sym[8] selects XOR vs XNOR chaining
   always_comb begin
      q_word      = sym[9] ? ~sym[7:0] : sym[7:0];
      dec_byte    = '0;
      dec_byte[0] = q_word[0];
      for (int i = 1; i < 8; i++) begin
         dec_byte[i] = sym[8] ? (q_word[i] ^ q_word[i-1]) : ~(q_word[i] ^ q_word[i-1]);
      end
   end

   assign run_complete = is_ctrl && (run_q == RW'(MIN_CTRL - 1));
   assign tmo_expired  = (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      wait_d  = wait_q;
      if (!is_ctrl)
         run_d = '0;
      else if (run_q == RW'(MIN_CTRL))
         run_d = run_q;
      else
         run_d = run_q + RW'(1);

      case (state_q)
         SEARCH: begin
            tmo_d = tmo_q + TW'(1);
            if (run_complete) begin
               state_d = LOCKED;
               tmo_d   = '0;
            end else if (tmo_expired) begin
               state_d = SLIP;
            end
         end
         SLIP: begin
            state_d = WAIT;
            run_d   = '0;
            tmo_d   = '0;
            wait_d  = '0;
         end
         WAIT: begin
            run_d  = '0;
            wait_d = wait_q + WW'(1);
            if (wait_q == WW'(SLIP_WAIT - 1)) begin
               state_d = SEARCH;
               wait_d  = '0;
            end
         end
         LOCKED: begin
            tmo_d = tmo_q + TW'(1);
            // a saturated run_cnt cannot re-complete, so a long run refreshes only once
            if (run_complete) begin
               tmo_d = '0;
            end else if (tmo_expired) begin
               state_d = SEARCH;
               tmo_d   = '0;
               run_d   = '0;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SEARCH;
         run_q     <= '0;
         tmo_q     <= '0;
         wait_q    <= '0;
         data_q    <= '0;
         de_q      <= 1'b0;
         c0_q      <= 1'b0;
         c1_q      <= 1'b0;
         aligned_q <= 1'b0;
         bitslip_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         tmo_q     <= tmo_d;
         wait_q    <= wait_d;
         aligned_q <= (state_d == LOCKED);
         bitslip_q <= (state_d == SLIP);
         if (!aligned_q) begin
            de_q   <= 1'b0;
            data_q <= '0;
         end else if (is_ctrl) begin
            de_q   <= 1'b0;
            data_q <= '0;
            c0_q   <= ctrl_val[0];
            c1_q   <= ctrl_val[1];
         end else begin
            de_q   <= 1'b1;
            data_q <= dec_byte;
         end
      end
   end

   assign data    = data_q;
   assign de      = de_q;
   assign c0      = c0_q;
   assign c1      = c1_q;
   assign aligned = aligned_q;
   assign bitslip = bitslip_q;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb/tb_tmds_rx_channel.sv - randomized and directed checks of tmds_rx_channel against a cycle reference model.
module tb_tmds_rx_channel;

   localparam int MIN = 16;
   localparam int TO  = 4096;
   localparam int SW  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] sym = '0;
   logic [7:0] data;
   logic       de, c0, c1, aligned, bitslip;

   int checks = 0;
   int failures = 0;

   tmds_rx_channel #(.MIN_CTRL(MIN), .TIMEOUT(TO), .SLIP_WAIT(SW)) dut (
      .clk(clk), .rst(rst), .sym(sym), .data(data), .de(de),
      .c0(c0), .c1(c1), .aligned(aligned), .bitslip(bitslip)
   );

   always #5 clk = ~clk;

   logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   // reference model state: mode 0=search 1=slip 2=wait 3=locked
   int         m_mode, m_run, m_tmo, m_wait;
   logic [7:0] m_data;
   logic       m_de, m_c0, m_c1, m_al, m_bs;

   logic [12:0] dut_vec, mdl_vec;
   assign dut_vec = {data, de, c1, c0, aligned, bitslip};
   assign mdl_vec = {m_data, m_de, m_c1, m_c0, m_al, m_bs};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int tok_of(input logic [9:0] s);
      for (int i = 0; i < 4; i++)
         if (s == toks[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] dec_of(input logic [9:0] s);
      logic [7:0] q, d;
      q = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~s[8];
      return d;
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] s;
      s = 10'($urandom);
      while (tok_of(s) >= 0) s = 10'($urandom);
      return s;
   endfunction

   task automatic model_step(input logic [9:0] s, input logic r);
      int t;
      bit done;
      if (r) begin
         m_mode = 0; m_run = 0; m_tmo = 0; m_wait = 0;
         m_data = 0; m_de = 0; m_c0 = 0; m_c1 = 0; m_al = 0; m_bs = 0;
         return;
      end
      t = tok_of(s);
      if (m_al) begin
         if (t >= 0) begin m_de = 0; m_data = 0; m_c1 = t[1]; m_c0 = t[0]; end
         else begin m_de = 1; m_data = dec_of(s); end
      end else begin
         m_de = 0; m_data = 0;
      end
      done = (t >= 0) && (m_run == MIN - 1);
      if (t < 0) m_run = 0;
      else if (m_run < MIN) m_run++;
      case (m_mode)
         0: if (done) begin m_mode = 3; m_tmo = 0; end
            else if (m_tmo == TO - 1) m_mode = 1;
            else m_tmo++;
         1: begin m_mode = 2; m_run = 0; m_tmo = 0; m_wait = 0; end
         2: begin
               m_run = 0; m_wait++;
               if (m_wait == SW) begin m_mode = 0; m_wait = 0; end
            end
         default:
            if (done) m_tmo = 0;
            else if (m_tmo == TO - 1) begin m_mode = 0; m_tmo = 0; m_run = 0; end
            else m_tmo++;
      endcase
      m_al = (m_mode == 3);
      m_bs = (m_mode == 1);
   endtask

   task automatic step(input logic [9:0] s, input logic r);
      sym = s;
      rst = r;
      @(posedge clk);
      model_step(s, r);
      #1;
      check("cycle", 32'(dut_vec), 32'(mdl_vec));
   endtask

   initial begin
      int drop_e, slip_e, e, n, al_cnt, first_bs, second_bs, bs_locked;

      step(10'h000, 1'b1);
      step(10'h000, 1'b1);
      check("reset", 32'(dut_vec), 32'h0);

      // lock on 00 token
      for (int i = 0; i < 20; i++) begin
         step(10'h354, 1'b0);
         if (i == 14) check("pre_lock", 32'(aligned), 32'h0);
         if (i == 15) check("lock16", 32'(aligned), 32'h1);
      end
      check("ctrl00", 32'({c1, c0, de}), 32'h0);

      step(10'h100, 1'b0); check("dec_100", 32'({data, de}), 32'h001);
      step(10'h2FF, 1'b0); check("dec_2ff", 32'({data, de}), 32'h1FD);
      step(10'h200, 1'b0); check("dec_200", 32'({data, de}), 32'h1FF);
      check("ctrl_hold", 32'({c1, c0}), 32'h0);

      // random mix of token runs, data bursts and occasional resets
      n = 0;
      while (n < 3000) begin
         if ($urandom_range(0, 199) == 0) begin
            step(rand_data(), 1'b1); n++;
         end else if ($urandom_range(0, 2) == 0) begin
            int len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin step(10'($urandom), 1'b0); n++; end
         end else begin
            int len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin step(toks[$urandom_range(0, 3)], 1'b0); n++; end
         end
      end

      // reset in the middle of a data burst, then relock on token 11
      step(10'h0, 1'b1);
      for (int i = 0; i < 16; i++) step(10'h2AB, 1'b0);
      check("lock11", 32'(aligned), 32'h1);
      for (int i = 0; i < 3; i++) step(rand_data(), 1'b0);
      check("burst_de", 32'(de), 32'h1);
      step(rand_data(), 1'b1);
      check("rst_mid", 32'(dut_vec), 32'h0);
      for (int i = 0; i < 16; i++) begin
         step(10'h2AB, 1'b0);
         if (i == 14) check("relock_pre", 32'(aligned), 32'h0);
      end
      check("relock", 32'(aligned), 32'h1);
      step(10'h2AB, 1'b0);
      check("ctrl11", 32'({c1, c0}), 32'h3);

      // 15 tokens, a data symbol, then 16 tokens
      step(10'h0, 1'b1);
      for (int i = 0; i < 15; i++) step(10'h154, 1'b0);
      step(rand_data(), 1'b0);
      check("short_run", 32'(aligned), 32'h0);
      for (int i = 0; i < 16; i++) begin
         step(10'h154, 1'b0);
         if (i == 14) check("run2_15", 32'(aligned), 32'h0);
      end
      check("run2_16", 32'(aligned), 32'h1);

      // locked, then 15 tokens + 1 data forever: lock lost, then slip
      step(10'h0, 1'b1);
      for (int i = 0; i < 16; i++) step(10'h0AB, 1'b0);
      drop_e = -1; slip_e = -1; bs_locked = 0; e = 0;
      while (slip_e < 0 && e < 9000) begin
         step(((e % 16) < 15) ? 10'h0AB : rand_data(), 1'b0);
         e++;
         if (drop_e < 0 && !aligned) drop_e = e;
         if (slip_e < 0 && bitslip) slip_e = e;
         if (bitslip && aligned) bs_locked++;
      end
      check("drop_at", 32'(drop_e), 32'(TO));
      check("slip_after_drop", 32'(slip_e), 32'(2 * TO));
      check("no_slip_locked", 32'(bs_locked), 32'h0);

      // no tokens at all: periodic bitslip
      step(10'h0, 1'b1);
      first_bs = -1; second_bs = -1; al_cnt = 0;
      for (int k = 1; k <= 8300; k++) begin
         step(10'h155, 1'b0);
         if (bitslip) begin
            if (first_bs < 0) first_bs = k;
            else if (second_bs < 0) second_bs = k;
         end
         if (aligned) al_cnt++;
      end
      check("slip_first", 32'(first_bs), 32'(TO));
      check("slip_second", 32'(second_bs), 32'(2 * TO + SW + 1));
      check("never_aligned", 32'(al_cnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
